// File: rtl/sysnum_wb_pkg.sv
// Shared types for the cache-side Wishbone arbiter.
//   arb_state_t : arbiter FSM state (idle, owned by A, owned by B, timed-out abort)
//   arb_port_t  : requesting master identity (A = icache, B = dcache)
package sysnum_wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN_A,
        ARB_OWN_B,
        ARB_ABORT
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } arb_port_t;

endpackage

// File: rtl/wb_cache_arbiter.sv
// wb_cache_arbiter
//   Shares one pipelined Wishbone master port between the icache (port A) and
//   the dcache (port B). One owner per bus cycle, round-robin on contention,
//   one idle bubble between grants, and a bus-timeout abort for a hung owner.
// Ports
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_a_* / o_a_*                port A master request / response
//   i_b_* / o_b_*                port B master request / response
//   o_wb_* / i_wb_*              downstream master request / slave response
module wb_cache_arbiter
    import sysnum_wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic              i_a_we,
    input  logic [XLEN-1:0]   i_a_addr,
    input  logic [XLEN-1:0]   i_a_data,
    input  logic [XLEN/8-1:0] i_a_sel,
    output logic              o_a_stall,
    output logic              o_a_ack,
    output logic              o_a_err,
    output logic [XLEN-1:0]   o_a_data,
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic              i_b_we,
    input  logic [XLEN-1:0]   i_b_addr,
    input  logic [XLEN-1:0]   i_b_data,
    input  logic [XLEN/8-1:0] i_b_sel,
    output logic              o_b_stall,
    output logic              o_b_ack,
    output logic              o_b_err,
    output logic [XLEN-1:0]   o_b_data,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [XLEN-1:0]   o_wb_addr,
    output logic [XLEN-1:0]   o_wb_data,
    output logic [XLEN/8-1:0] o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [XLEN-1:0]   i_wb_data
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    // Written at grant time, so it names the current owner while in OWN/ABORT
    // and the most recent owner while in IDLE -- the round-robin reference.
    arb_port_t     last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic own_a, own_b, active, owner_cyc, timeout, pass;

    always_comb begin
        // Reset gates ownership immediately so a bus cycle is dropped in the
        // very cycle reset is sampled, not one cycle later.
        own_a     = !i_reset && (state_q == ARB_OWN_A);
        own_b     = !i_reset && (state_q == ARB_OWN_B);
        active    = own_a || own_b;
        owner_cyc = (last_owner_q == PORT_A) ? i_a_cyc : i_b_cyc;
        // Only a live bus cycle can time out; a dropping owner just releases.
        timeout   = active && owner_cyc && (cnt_q == CNT_LAST);
        pass      = active && !timeout;
    end

    // Request mux: downstream sees only the owner, and nothing on timeout.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        if (pass && own_a) begin
            o_wb_cyc  = i_a_cyc;
            o_wb_stb  = i_a_stb;
            o_wb_we   = i_a_we;
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
            o_wb_sel  = i_a_sel;
        end else if (pass && own_b) begin
            o_wb_cyc  = i_b_cyc;
            o_wb_stb  = i_b_stb;
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
        end
    end

    // Response routing: slave ack/err go to the owner only; the timeout cycle
    // replaces them with a local error and keeps the owner stalled.
    always_comb begin
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        o_a_data  = i_wb_data;
        o_b_data  = i_wb_data;
        if (own_a) begin
            if (timeout) begin
                o_a_err = 1'b1;
            end else begin
                o_a_stall = i_wb_stall;
                o_a_ack   = i_wb_ack;
                o_a_err   = i_wb_err;
            end
        end
        if (own_b) begin
            if (timeout) begin
                o_b_err = 1'b1;
            end else begin
                o_b_stall = i_wb_stall;
                o_b_ack   = i_wb_ack;
                o_b_err   = i_wb_err;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (i_a_cyc && i_b_cyc) begin
                    last_owner_d = (last_owner_q == PORT_A) ? PORT_B : PORT_A;
                    state_d      = (last_owner_q == PORT_A) ? ARB_OWN_B : ARB_OWN_A;
                end else if (i_a_cyc) begin
                    last_owner_d = PORT_A;
                    state_d      = ARB_OWN_A;
                end else if (i_b_cyc) begin
                    last_owner_d = PORT_B;
                    state_d      = ARB_OWN_B;
                end
            end
            ARB_OWN_A, ARB_OWN_B: begin
                if (!owner_cyc) begin
                    state_d = ARB_IDLE;
                end else if (timeout) begin
                    state_d = ARB_ABORT;
                end else if (i_wb_ack || i_wb_err) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_ABORT: begin
                cnt_d = '0;
                if (!owner_cyc) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= PORT_A;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_cache_arbiter.sv
module tb_wb_cache_arbiter;

    localparam int XLEN    = 32;
    localparam int SW      = XLEN / 8;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_a_cyc, i_a_stb, i_a_we;
    logic [XLEN-1:0] i_a_addr, i_a_data;
    logic [SW-1:0]   i_a_sel;
    logic            o_a_stall, o_a_ack, o_a_err;
    logic [XLEN-1:0] o_a_data;
    logic            i_b_cyc, i_b_stb, i_b_we;
    logic [XLEN-1:0] i_b_addr, i_b_data;
    logic [SW-1:0]   i_b_sel;
    logic            o_b_stall, o_b_ack, o_b_err;
    logic [XLEN-1:0] o_b_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [XLEN-1:0] o_wb_addr, o_wb_data;
    logic [SW-1:0]   o_wb_sel;
    logic            i_wb_stall, i_wb_ack, i_wb_err;
    logic [XLEN-1:0] i_wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    wb_cache_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
        .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_sel(i_a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
        .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_sel(i_b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, outputs are checked at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
        i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
        i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h40;
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_cyc got %b want 0", o_wb_cyc); end
            n_checks++; if (o_a_stall !== 1'b1) begin n_fail++; $display("FAIL reset_a_stall got %b want 1", o_a_stall); end
        end
        rst = 0; #1;
        n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_arb_latency got %b want 0", o_wb_cyc); end
        tick(); #1;
        n_checks++; if (o_wb_cyc !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant got %b want 1", o_wb_cyc); end
        // reset while owning: cycle dropped and ack swallowed at once
        rst = 1; i_wb_ack = 1; #1;
        n_checks++; if ({o_wb_cyc, o_a_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_midcycle got cyc/ack %b want 00", {o_wb_cyc, o_a_ack}); end
        tick(); idle_inputs(); rst = 0;
    endtask

    task automatic test_a_alone();
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h100; i_a_sel = 4'hF; #1;
        n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL a_alone_latency got %b want 0", o_wb_cyc); end
        tick(); #1;
        n_checks++; if ({o_wb_cyc, o_wb_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL a_alone_grant got %b/%h want 1/00000100", o_wb_cyc, o_wb_addr); end
        i_a_stb = 0; i_wb_ack = 1; i_wb_data = 32'hDEADBEEF; #1;
        n_checks++; if ({o_a_ack, o_a_data, o_b_ack} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL a_alone_ack got %b/%h/%b want 1/deadbeef/0", o_a_ack, o_a_data, o_b_ack);
        end
        tick(); idle_inputs(); tick();
    endtask

    task automatic test_contention();
        rst = 1; tick(); tick(); rst = 0;
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h200;
        i_b_cyc = 1; i_b_stb = 1; i_b_addr = 32'h300; #1;
        n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL cont_latency got %b want 0", o_wb_cyc); end
        tick(); #1;
        n_checks++; if ({o_wb_addr, o_b_stall, o_a_stall} !== {32'h300, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL cont_b_first got %h/%b/%b want 00000300/0/1", o_wb_addr, o_b_stall, o_a_stall);
        end
        i_b_cyc = 0; i_b_stb = 0; tick(); #1;
        n_checks++; if ({o_wb_cyc, o_a_stall} !== 2'b01) begin n_fail++; $display("FAIL cont_bubble got %b want 01", {o_wb_cyc, o_a_stall}); end
        tick(); #1;
        n_checks++; if ({o_wb_cyc, o_wb_addr, o_a_stall} !== {1'b1, 32'h200, 1'b0}) begin
            n_fail++; $display("FAIL cont_a_second got %b/%h/%b want 1/00000200/0", o_wb_cyc, o_wb_addr, o_a_stall);
        end
        idle_inputs(); tick();
    endtask

    task automatic test_burst_hold();
        int acc;
        acc = 0;
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'hA000;
        i_b_cyc = 1; i_b_we = 1;
        tick();
        for (int c = 0; c < 6; c++) begin
            i_b_stb = (acc < 4); i_b_addr = 32'h1000 + 32'(4 * acc);
            i_wb_stall = (c < 2); i_wb_ack = (c >= 2); #1;
            n_checks++;
            if ({o_b_stall, o_a_stall, o_wb_stb, o_wb_we, o_wb_addr} !== {(c < 2), 1'b1, 1'b1, 1'b1, 32'h1000 + 32'(4 * acc)}) begin
                n_fail++; $display("FAIL burst_c%0d got stall_b=%b stall_a=%b stb=%b we=%b addr=%h", c, o_b_stall, o_a_stall, o_wb_stb, o_wb_we, o_wb_addr);
            end
            if (!i_wb_stall && i_b_stb) acc++;
            tick();
        end
        i_b_stb = 0; i_b_cyc = 0; i_wb_stall = 0; i_wb_ack = 0; #1;
        n_checks++; if (o_a_stall !== 1'b1) begin n_fail++; $display("FAIL burst_no_preempt got %b want 1", o_a_stall); end
        tick(); #1;
        n_checks++; if ({o_wb_cyc, o_a_stall} !== 2'b01) begin n_fail++; $display("FAIL burst_bubble got %b want 01", {o_wb_cyc, o_a_stall}); end
        tick(); #1;
        n_checks++; if ({o_a_stall, o_wb_addr} !== {1'b0, 32'hA000}) begin n_fail++; $display("FAIL burst_a_grant got %b/%h want 0/0000a000", o_a_stall, o_wb_addr); end
        idle_inputs(); tick();
    endtask

    task automatic test_timeout();
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h500;
        tick();
        i_b_cyc = 1; i_b_stb = 1; i_b_addr = 32'h600;
        for (int k = 1; k <= TIMEOUT; k++) begin
            i_wb_ack = (k == TIMEOUT); #1;
            n_checks++;
            if (k < TIMEOUT) begin
                if ({o_wb_cyc, o_a_err} !== 2'b10) begin n_fail++; $display("FAIL timeout_owned_%0d got cyc/err %b want 10", k, {o_wb_cyc, o_a_err}); end
            end else begin
                if ({o_wb_cyc, o_a_err, o_a_ack, o_b_err} !== 4'b0100) begin
                    n_fail++; $display("FAIL timeout_fire got cyc/err/ack/berr %b want 0100", {o_wb_cyc, o_a_err, o_a_ack, o_b_err});
                end
            end
            tick();
        end
        i_wb_ack = 0;
        for (int k = 0; k < 2; k++) begin
            #1; n_checks++;
            if ({o_wb_cyc, o_a_stall, o_a_err, o_b_stall} !== 4'b0101) begin
                n_fail++; $display("FAIL timeout_abort_%0d got %b want 0101", k, {o_wb_cyc, o_a_stall, o_a_err, o_b_stall});
            end
            tick();
        end
        i_a_cyc = 0; i_a_stb = 0; tick(); #1;
        n_checks++; if ({o_wb_cyc, o_b_stall} !== 2'b01) begin n_fail++; $display("FAIL timeout_bubble got %b want 01", {o_wb_cyc, o_b_stall}); end
        tick(); #1;
        n_checks++; if ({o_wb_cyc, o_b_stall, o_wb_addr} !== {2'b10, 32'h600}) begin
            n_fail++; $display("FAIL timeout_b_grant got %b/%b/%h want 1/0/00000600", o_wb_cyc, o_b_stall, o_wb_addr);
        end
        idle_inputs(); tick();
    endtask

    task automatic test_err_passthrough();
        i_b_cyc = 1; i_b_stb = 1; tick();
        i_wb_err = 1; #1;
        n_checks++; if ({o_b_err, o_a_err, o_b_ack} !== 3'b100) begin n_fail++; $display("FAIL err_pass got berr/aerr/back %b want 100", {o_b_err, o_a_err, o_b_ack}); end
        idle_inputs(); tick(); tick();
    endtask

    // Reference model: who holds the bus, whether the tenure was aborted, how
    // long since the last slave response, and who was served last.
    task automatic test_random();
        int owner, last, age;
        bit aborted, x_cyc, tmo;
        logic [XLEN+XLEN+SW+2:0] e_req, g_req;
        logic [5:0] e_rsp, g_rsp;
        rst = 1; idle_inputs(); tick(); rst = 0;
        owner = 0; last = 1; age = 0; aborted = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            i_a_cyc = i_a_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            i_b_cyc = i_b_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            i_a_stb = 1'($urandom); i_a_we = 1'($urandom); i_a_addr = $urandom; i_a_data = $urandom; i_a_sel = SW'($urandom);
            i_b_stb = 1'($urandom); i_b_we = 1'($urandom); i_b_addr = $urandom; i_b_data = $urandom; i_b_sel = SW'($urandom);
            i_wb_stall = ($urandom_range(0, 9) < 3);
            i_wb_ack   = ((cyc / 100) % 2 == 0) && ($urandom_range(0, 9) < 4);
            i_wb_err   = ($urandom_range(0, 19) == 0);
            i_wb_data  = $urandom;
            #1;
            x_cyc = (owner == 1) ? i_a_cyc : (owner == 2) ? i_b_cyc : 1'b0;
            tmo   = (owner != 0) && !aborted && x_cyc && (age == TIMEOUT - 1);
            e_req = '0;
            e_rsp = 6'b100100;  // {a_stall,a_ack,a_err,b_stall,b_ack,b_err}
            if (owner != 0 && !aborted) begin
                if (tmo) begin
                    if (owner == 1) e_rsp[3] = 1'b1; else e_rsp[0] = 1'b1;
                end else if (owner == 1) begin
                    e_req = {i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data, i_a_sel};
                    e_rsp[5:3] = {i_wb_stall, i_wb_ack, i_wb_err};
                end else begin
                    e_req = {i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel};
                    e_rsp[2:0] = {i_wb_stall, i_wb_ack, i_wb_err};
                end
            end
            g_req = {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel};
            g_rsp = {o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err};
            n_checks++;
            if (g_req !== e_req || g_rsp !== e_rsp || o_a_data !== i_wb_data || o_b_data !== i_wb_data) begin
                n_fail++; $display("FAIL rand_cycle_%0d got req=%h rsp=%b want req=%h rsp=%b", cyc, g_req, g_rsp, e_req, e_rsp);
            end
            if (owner == 0) begin
                age = 0;
                if (i_a_cyc && i_b_cyc) owner = (last == 1) ? 2 : 1;
                else if (i_a_cyc) owner = 1;
                else if (i_b_cyc) owner = 2;
            end else if (!x_cyc) begin
                last = owner; owner = 0; aborted = 0;
            end else if (!aborted) begin
                if (tmo) aborted = 1;
                else age = (i_wb_ack || i_wb_err) ? 0 : age + 1;
            end
            tick();
        end
        idle_inputs(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_a_alone();
        test_contention();
        test_burst_hold();
        test_timeout();
        test_err_passthrough();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
